icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, word width; ADDR_WIDTH, default 16, word address width; BLOCK_OFFSET_WIDTH, default 5, words per line = 2^BLOCK_OFFSET_WIDTH; INDEX_WIDTH, default 3, line count = 2^INDEX_WIDTH.
REQ-002 Address split SHALL be [tag 8 | index 3 | offset 5], one word per address.
REQ-003 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_addr  in  16  fetch word address.
- cpu_req  in  1  fetch request; held high until cpu_ready.
- flush  in  1  invalidate all lines.
- cpu_rdata  out  32  fetched word.
- cpu_ready  out  1  one-cycle pulse; cpu_rdata valid.
- cpu_stall  out  1  high whenever state != IDLE.
- mem_addr  out  16  refill block base address.
- mem_enable  out  1  one-cycle start pulse to memory controller.
- mem_rw  out  1  constant 0 (read).
- mem_op_size  out  1  constant 0 (whole block).
- mem_finishes_op  out  1  constant 0.
- mem_data_read  in  32  refill word.
- mem_data_read_valid  in  1  refill word strobe.
- mem_finished  in  1  refill complete strobe.

Function
REQ-004 Storage SHALL be direct-mapped: 8 lines x 32 words, one 8-bit tag and one valid bit per line; read-only, no write path.
REQ-005 FSM states SHALL be IDLE, MISS_REQ, REFILL, RESPOND.
REQ-006 IDLE, flush=1: all valid bits cleared at that edge; any cpu_req that cycle SHALL NOT be accepted (flush wins).
REQ-007 IDLE, cpu_req=1, flush=0, hit (valid && tag match): cpu_rdata <= line word at offset, cpu_ready=1 next cycle, state stays IDLE; hit latency = 1 cycle.
REQ-008 IDLE, cpu_req=1, flush=0, miss: latch cpu_addr, go MISS_REQ.
REQ-009 MISS_REQ: mem_enable=1 for exactly one cycle, mem_addr={tag,index,5'b0}, refill counter <= 0, go REFILL; mem_addr SHALL stay stable until return to IDLE.
REQ-010 REFILL: each cycle mem_data_read_valid=1 with counter<32, write mem_data_read to word[counter] of the latched index, counter++; strobes with counter>=32 SHALL be ignored.
REQ-011 REFILL: on mem_finished=1, that cycle's valid word (if counter<32) SHALL still be written; then tag <= latched tag, valid <= 1, go RESPOND.
REQ-012 RESPOND: cpu_rdata <= word[latched offset] of the refilled line, cpu_ready=1 for one cycle, go IDLE.
REQ-013 Miss latency SHALL be (cycles from mem_enable to mem_finished) + 3 cycles from request acceptance; cpu_stall high from MISS_REQ through RESPOND inclusive.
REQ-014 Line valid bit SHALL remain 0 during REFILL so partial lines never hit.
REQ-015 flush outside IDLE SHALL set flush_pending; applied (all valid cleared, including the just-filled line) on entry to IDLE, ahead of any request that cycle.
REQ-016 cpu_addr changes during a miss SHALL be ignored; the latched address governs response.
REQ-017 Counter SHALL be 6 bits and SHALL NOT wrap into word 0.

Reset
REQ-018 rst_n=0 SHALL asynchronously force: state IDLE, all valid bits 0, flush_pending 0, counter 0, cpu_rdata 0, cpu_ready 0, cpu_stall 0, mem_enable 0, mem_addr 0; data array contents unspecified.
REQ-019 Reset mid-REFILL SHALL abandon the fill; line stays invalid; any memory-controller strobes after reset release in IDLE SHALL be ignored.

Verification
REQ-020 Cold miss: reset, req 0x1234 -> one mem_enable pulse, mem_addr 0x1220; after 32 beats of value (0xA000+i) plus mem_finished, cpu_ready with cpu_rdata 0xA014.
REQ-021 Hit: then req 0x123F -> cpu_ready next cycle, cpu_rdata 0xA01F, no mem_enable.
REQ-022 Conflict: req 0x5634 (same index 1, tag 0x56) -> refill at 0x5620; following req 0x1234 misses again.
REQ-023 Flush: flush pulse in IDLE together with req 0x1234 -> no ready that cycle; the held request then misses.
REQ-024 Flush during REFILL: pending flush applied; same address re-request misses.
REQ-025 Extra beat: 33 valid strobes, last with mem_finished -> words 0..31 correct, no corruption of word 0.

Source files
------------

// File: rtl/icache_if.sv
// -----------------------------------------------------------------------------
// icache_if -- bundle of every signal between the instruction cache, the fetch
// unit in front of it and the block-refill memory controller behind it.
//
// Signals
//   cpu_addr            fetch word address (to cache)
//   cpu_req             fetch request, held until cpu_ready (to cache)
//   flush               invalidate every line (to cache)
//   cpu_rdata           fetched word (from cache)
//   cpu_ready           one-cycle pulse, cpu_rdata valid (from cache)
//   cpu_stall           cache busy with a miss (from cache)
//   mem_addr            refill block base address (from cache)
//   mem_enable          one-cycle refill start pulse (from cache)
//   mem_rw              always read (from cache)
//   mem_op_size         always whole block (from cache)
//   mem_finishes_op     tied low (from cache)
//   mem_data_read       refill word (to cache)
//   mem_data_read_valid refill word strobe (to cache)
//   mem_finished        refill complete strobe (to cache)
//
// Modports
//   slave  : the cache itself
//   master : the surrounding fetch unit / memory controller (or a bench)
// -----------------------------------------------------------------------------
interface icache_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  cpu_req;
    logic                  flush;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ready;
    logic                  cpu_stall;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_enable;
    logic                  mem_rw;
    logic                  mem_op_size;
    logic                  mem_finishes_op;
    logic [DATA_WIDTH-1:0] mem_data_read;
    logic                  mem_data_read_valid;
    logic                  mem_finished;

    modport slave (
        input  cpu_addr, cpu_req, flush,
        input  mem_data_read, mem_data_read_valid, mem_finished,
        output cpu_rdata, cpu_ready, cpu_stall,
        output mem_addr, mem_enable, mem_rw, mem_op_size, mem_finishes_op
    );

    modport master (
        output cpu_addr, cpu_req, flush,
        output mem_data_read, mem_data_read_valid, mem_finished,
        input  cpu_rdata, cpu_ready, cpu_stall,
        input  mem_addr, mem_enable, mem_rw, mem_op_size, mem_finishes_op
    );
endinterface

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache -- read-only, direct-mapped instruction cache.
//
// 2^INDEX_WIDTH lines of 2^BLOCK_OFFSET_WIDTH words, one tag and one valid bit
// per line. Hits answer one cycle after the request is sampled; misses fetch
// the whole line from the memory controller (one start pulse, a stream of
// word strobes, then a finished strobe) and answer from the refilled line.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : icache_if.slave -- fetch side (cpu_*, flush) and refill side
//            (mem_*); all cache outputs are registered except the tie-offs.
// -----------------------------------------------------------------------------
module icache #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 16,
    parameter int BLOCK_OFFSET_WIDTH = 5,
    parameter int INDEX_WIDTH        = 3
) (
    input logic     clk,
    input logic     rst_n,
    icache_if.slave bus
);
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - BLOCK_OFFSET_WIDTH;
    localparam int LINES     = 2 ** INDEX_WIDTH;
    localparam int WORDS     = 2 ** BLOCK_OFFSET_WIDTH;
    localparam int CNT_WIDTH = BLOCK_OFFSET_WIDTH + 1;

    // One count past the last word: beats beyond it are dropped instead of
    // wrapping onto word 0.
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(WORDS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MISS_REQ = 2'd1,
        REFILL   = 2'd2,
        RESPOND  = 2'd3
    } state_t;

    state_t state_r;
    state_t state_next_s;

    // Storage
    logic [DATA_WIDTH-1:0]         data_r [LINES*WORDS];
    logic [TAG_WIDTH-1:0]          tag_r  [LINES];
    logic [LINES-1:0]              valid_r;

    // Miss bookkeeping
    logic [TAG_WIDTH-1:0]          lat_tag_r;
    logic [INDEX_WIDTH-1:0]        lat_index_r;
    logic [BLOCK_OFFSET_WIDTH-1:0] lat_offset_r;
    logic [CNT_WIDTH-1:0]          counter_r;
    logic                          flush_pending_r;

    // Registered outputs
    logic [DATA_WIDTH-1:0]         rdata_r;
    logic                          ready_r;
    logic                          stall_r;
    logic                          mem_en_r;
    logic [ADDR_WIDTH-1:0]         mem_addr_r;

    // Address decode and control strobes
    logic [TAG_WIDTH-1:0]          cpu_tag_s;
    logic [INDEX_WIDTH-1:0]        cpu_index_s;
    logic [BLOCK_OFFSET_WIDTH-1:0] cpu_offset_s;
    logic                          hit_s;
    logic                          flush_apply_s;
    logic                          accept_hit_s;
    logic                          accept_miss_s;
    logic                          start_mem_s;
    logic                          write_beat_s;
    logic                          fill_done_s;
    logic                          respond_s;

    assign cpu_tag_s    = bus.cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign cpu_index_s  = bus.cpu_addr[BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
    assign cpu_offset_s = bus.cpu_addr[BLOCK_OFFSET_WIDTH-1:0];
    assign hit_s        = valid_r[cpu_index_s] && (tag_r[cpu_index_s] == cpu_tag_s);

    assign bus.cpu_rdata       = rdata_r;
    assign bus.cpu_ready       = ready_r;
    assign bus.cpu_stall       = stall_r;
    assign bus.mem_addr        = mem_addr_r;
    assign bus.mem_enable      = mem_en_r;
    assign bus.mem_rw          = 1'b0;
    assign bus.mem_op_size     = 1'b0;
    assign bus.mem_finishes_op = 1'b0;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state and per-cycle control strobes
    always_comb begin
        state_next_s  = state_r;
        flush_apply_s = 1'b0;
        accept_hit_s  = 1'b0;
        accept_miss_s = 1'b0;
        start_mem_s   = 1'b0;
        write_beat_s  = 1'b0;
        fill_done_s   = 1'b0;
        respond_s     = 1'b0;
        case (state_r)
            IDLE: begin
                // A live or deferred flush owns the cycle; any request waits.
                if (bus.flush || flush_pending_r) begin
                    flush_apply_s = 1'b1;
                end else if (bus.cpu_req) begin
                    if (hit_s) begin
                        accept_hit_s = 1'b1;
                    end else begin
                        accept_miss_s = 1'b1;
                        state_next_s  = MISS_REQ;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            MISS_REQ: begin
                start_mem_s  = 1'b1;
                state_next_s = REFILL;
            end
            REFILL: begin
                write_beat_s = bus.mem_data_read_valid && (counter_r < CNT_LIMIT);
                if (bus.mem_finished) begin
                    fill_done_s  = 1'b1;
                    state_next_s = RESPOND;
                end else begin
                    state_next_s = REFILL;
                end
            end
            RESPOND: begin
                respond_s    = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Control registers, valid bits and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r         <= {LINES{1'b0}};
            lat_tag_r       <= {TAG_WIDTH{1'b0}};
            lat_index_r     <= {INDEX_WIDTH{1'b0}};
            lat_offset_r    <= {BLOCK_OFFSET_WIDTH{1'b0}};
            counter_r       <= {CNT_WIDTH{1'b0}};
            flush_pending_r <= 1'b0;
            rdata_r         <= {DATA_WIDTH{1'b0}};
            ready_r         <= 1'b0;
            stall_r         <= 1'b0;
            mem_en_r        <= 1'b0;
            mem_addr_r      <= {ADDR_WIDTH{1'b0}};
        end else begin
            ready_r  <= accept_hit_s || respond_s;
            mem_en_r <= start_mem_s;
            stall_r  <= (state_next_s != IDLE);

            if (flush_apply_s) begin
                flush_pending_r <= 1'b0;
            end else if (bus.flush) begin
                flush_pending_r <= 1'b1;
            end

            if (accept_hit_s) begin
                rdata_r <= data_r[{cpu_index_s, cpu_offset_s}];
            end else if (respond_s) begin
                rdata_r <= data_r[{lat_index_r, lat_offset_r}];
            end

            if (accept_miss_s) begin
                lat_tag_r    <= cpu_tag_s;
                lat_index_r  <= cpu_index_s;
                lat_offset_r <= cpu_offset_s;
            end

            if (start_mem_s) begin
                mem_addr_r <= {lat_tag_r, lat_index_r, {BLOCK_OFFSET_WIDTH{1'b0}}};
                counter_r  <= {CNT_WIDTH{1'b0}};
            end else if (write_beat_s) begin
                counter_r <= counter_r + CNT_ONE;
            end

            // The victim line is invalidated as soon as the miss is taken, so
            // a partially refilled line (or one abandoned by reset) never hits.
            if (flush_apply_s) begin
                valid_r <= {LINES{1'b0}};
            end else if (accept_miss_s) begin
                valid_r[cpu_index_s] <= 1'b0;
            end else if (fill_done_s) begin
                valid_r[lat_index_r] <= 1'b1;
            end
        end
    end

    // Data and tag arrays; contents need no reset because valid bits gate use
    always_ff @(posedge clk) begin
        if (write_beat_s) begin
            data_r[{lat_index_r, counter_r[BLOCK_OFFSET_WIDTH-1:0]}] <= bus.mem_data_read;
        end
        if (fill_done_s) begin
            tag_r[lat_index_r] <= lat_tag_r;
        end
    end
endmodule

// File: tb/tb_icache.sv
// -----------------------------------------------------------------------------
// tb_icache -- directed bench for icache: reset state, cold miss, hit,
// conflict miss, flush in IDLE, flush during refill, surplus refill beat and
// reset in the middle of a refill. Expected words are hand-computed from the
// refill pattern (base + beat number) and the offset of each address.
// -----------------------------------------------------------------------------
module tb_icache;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;
    int   en_count = 0;

    icache_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

    icache dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count refill start pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.mem_enable === 1'b1) en_count <= en_count + 1;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    task automatic issue_req(input logic [15:0] addr);
        @(negedge clk);
        bus.cpu_addr = addr;
        bus.cpu_req  = 1'b1;
    endtask

    task automatic wait_enable(output logic seen, output logic [15:0] addr);
        int n = 0;
        while (bus.mem_enable !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        seen = (bus.mem_enable === 1'b1);
        addr = bus.mem_addr;
    endtask

    task automatic drive_beats(input logic [31:0] base, input int n, input logic finish);
        for (int i = 0; i < n; i++) begin
            bus.mem_data_read       = base + 32'(i);
            bus.mem_data_read_valid = 1'b1;
            bus.mem_finished        = finish && (i == n - 1);
            @(negedge clk);
        end
        bus.mem_data_read_valid = 1'b0;
        bus.mem_finished        = 1'b0;
    endtask

    task automatic wait_ready(output logic got, output logic [31:0] data, output int cyc);
        got  = 1'b0;
        data = 32'h0;
        cyc  = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.cpu_ready === 1'b1) begin
                got         = 1'b1;
                data        = bus.cpu_rdata;
                bus.cpu_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (bus.cpu_rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", bus.cpu_rdata); else pass_cnt++;
        total_cnt++; if (bus.cpu_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", bus.cpu_ready); else pass_cnt++;
        total_cnt++; if (bus.cpu_stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", bus.cpu_stall); else pass_cnt++;
        total_cnt++; if (bus.mem_enable !== 1'b0) $display("FAIL reset_mem_enable got=%b exp=0", bus.mem_enable); else pass_cnt++;
        total_cnt++; if (bus.mem_addr !== 16'h0) $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); else pass_cnt++;
        total_cnt++;
        if ({bus.mem_rw, bus.mem_op_size, bus.mem_finishes_op} !== 3'b000)
            $display("FAIL tie_offs got=%b exp=000", {bus.mem_rw, bus.mem_op_size, bus.mem_finishes_op});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cold_miss();
        logic seen; logic [15:0] maddr; logic got; logic [31:0] d; int cyc; int en0;
        en0 = en_count;
        issue_req(16'h1234);
        wait_enable(seen, maddr);
        total_cnt++; if (seen !== 1'b1) $display("FAIL cold_mem_enable got=%b exp=1", seen); else pass_cnt++;
        total_cnt++; if (maddr !== 16'h1220) $display("FAIL cold_mem_addr got=%h exp=1220", maddr); else pass_cnt++;
        total_cnt++; if (bus.cpu_stall !== 1'b1) $display("FAIL cold_stall got=%b exp=1", bus.cpu_stall); else pass_cnt++;
        drive_beats(32'h0000A000, 32, 1'b1);
        wait_ready(got, d, cyc);
        total_cnt++; if (got !== 1'b1) $display("FAIL cold_ready got=%b exp=1", got); else pass_cnt++;
        total_cnt++; if (d !== 32'h0000A014) $display("FAIL cold_rdata got=%h exp=0000a014", d); else pass_cnt++;
        total_cnt++; if (cyc !== 1) $display("FAIL cold_respond_delay got=%0d exp=1", cyc); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (en_count - en0 !== 1) $display("FAIL cold_enable_pulses got=%0d exp=1", en_count - en0); else pass_cnt++;
        total_cnt++; if (bus.cpu_stall !== 1'b0) $display("FAIL cold_stall_after got=%b exp=0", bus.cpu_stall); else pass_cnt++;
    endtask

    task automatic test_hit();
        logic got; logic [31:0] d; int cyc; int en0;
        en0 = en_count;
        issue_req(16'h123F);
        wait_ready(got, d, cyc);
        total_cnt++; if (got !== 1'b1) $display("FAIL hit_ready got=%b exp=1", got); else pass_cnt++;
        total_cnt++; if (d !== 32'h0000A01F) $display("FAIL hit_rdata got=%h exp=0000a01f", d); else pass_cnt++;
        total_cnt++; if (cyc !== 1) $display("FAIL hit_latency got=%0d exp=1", cyc); else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++; if (en_count !== en0) $display("FAIL hit_no_mem_enable got=%0d exp=%0d", en_count, en0); else pass_cnt++;
    endtask

    task automatic test_conflict();
        logic seen; logic [15:0] maddr; logic got; logic [31:0] d; int cyc;
        issue_req(16'h5634);
        wait_enable(seen, maddr);
        total_cnt++; if (seen !== 1'b1) $display("FAIL conflict_miss got=%b exp=1", seen); else pass_cnt++;
        total_cnt++; if (maddr !== 16'h5620) $display("FAIL conflict_mem_addr got=%h exp=5620", maddr); else pass_cnt++;
        drive_beats(32'h0000B000, 32, 1'b1);
        wait_ready(got, d, cyc);
        total_cnt++; if (d !== 32'h0000B014) $display("FAIL conflict_rdata got=%h exp=0000b014", d); else pass_cnt++;
        issue_req(16'h1234);
        wait_enable(seen, maddr);
        total_cnt++; if (seen !== 1'b1) $display("FAIL conflict_remiss got=%b exp=1", seen); else pass_cnt++;
        total_cnt++; if (maddr !== 16'h1220) $display("FAIL conflict_remiss_addr got=%h exp=1220", maddr); else pass_cnt++;
        drive_beats(32'h0000A000, 32, 1'b1);
        wait_ready(got, d, cyc);
        total_cnt++; if (d !== 32'h0000A014) $display("FAIL conflict_remiss_rdata got=%h exp=0000a014", d); else pass_cnt++;
    endtask

    task automatic test_flush_idle();
        logic seen; logic [15:0] maddr; logic got; logic [31:0] d; int cyc;
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.cpu_addr = 16'h1234;
        bus.cpu_req  = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++; if (bus.cpu_ready !== 1'b0) $display("FAIL flush_blocks_req got=%b exp=0", bus.cpu_ready); else pass_cnt++;
        @(negedge clk);
        bus.flush = 1'b0;
        wait_enable(seen, maddr);
        total_cnt++; if (seen !== 1'b1) $display("FAIL flush_then_miss got=%b exp=1", seen); else pass_cnt++;
        drive_beats(32'h0000C000, 32, 1'b1);
        wait_ready(got, d, cyc);
        total_cnt++; if (d !== 32'h0000C014) $display("FAIL flush_rdata got=%h exp=0000c014", d); else pass_cnt++;
    endtask

    task automatic test_flush_refill();
        logic seen; logic [15:0] maddr; logic got; logic [31:0] d; int cyc;
        issue_req(16'h0040);
        wait_enable(seen, maddr);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        drive_beats(32'h0000D000, 32, 1'b1);
        wait_ready(got, d, cyc);
        total_cnt++; if (d !== 32'h0000D000) $display("FAIL flushfill_rdata got=%h exp=0000d000", d); else pass_cnt++;
        issue_req(16'h0040);
        wait_enable(seen, maddr);
        total_cnt++; if (seen !== 1'b1) $display("FAIL flushfill_remiss got=%b exp=1", seen); else pass_cnt++;
        drive_beats(32'h0000E000, 32, 1'b1);
        wait_ready(got, d, cyc);
        total_cnt++; if (d !== 32'h0000E000) $display("FAIL flushfill_rdata2 got=%h exp=0000e000", d); else pass_cnt++;
    endtask

    task automatic test_extra_beat();
        logic seen; logic [15:0] maddr; logic got; logic [31:0] d; int cyc;
        issue_req(16'h00A0);
        wait_enable(seen, maddr);
        drive_beats(32'h0000F000, 33, 1'b1);
        wait_ready(got, d, cyc);
        total_cnt++; if (d !== 32'h0000F000) $display("FAIL extra_word0 got=%h exp=0000f000", d); else pass_cnt++;
        issue_req(16'h00BF);
        wait_ready(got, d, cyc);
        total_cnt++; if (d !== 32'h0000F01F) $display("FAIL extra_word31 got=%h exp=0000f01f", d); else pass_cnt++;
        issue_req(16'h00A1);
        wait_ready(got, d, cyc);
        total_cnt++; if (d !== 32'h0000F001) $display("FAIL extra_word1 got=%h exp=0000f001", d); else pass_cnt++;
    endtask

    task automatic test_reset_midfill();
        logic seen; logic [15:0] maddr; logic got; logic [31:0] d; int cyc;
        issue_req(16'h5634);
        wait_enable(seen, maddr);
        drive_beats(32'h00001100, 5, 1'b0);
        #2;
        rst_n       = 1'b0;
        bus.cpu_req = 1'b0;
        #1;
        total_cnt++; if (bus.cpu_stall !== 1'b0) $display("FAIL midreset_stall got=%b exp=0", bus.cpu_stall); else pass_cnt++;
        total_cnt++; if (bus.mem_addr !== 16'h0) $display("FAIL midreset_mem_addr got=%h exp=0", bus.mem_addr); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_data_read       = 32'hDEADBEEF;
        bus.mem_data_read_valid = 1'b1;
        bus.mem_finished        = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({bus.cpu_ready, bus.cpu_stall} !== 2'b00)
            $display("FAIL midreset_stray_strobes got=%b exp=00", {bus.cpu_ready, bus.cpu_stall});
        else pass_cnt++;
        @(negedge clk);
        bus.mem_data_read_valid = 1'b0;
        bus.mem_finished        = 1'b0;
        issue_req(16'h1234);
        wait_enable(seen, maddr);
        total_cnt++; if (seen !== 1'b1) $display("FAIL midreset_line_invalid got=%b exp=1", seen); else pass_cnt++;
        drive_beats(32'h0000A000, 32, 1'b1);
        wait_ready(got, d, cyc);
        total_cnt++; if (d !== 32'h0000A014) $display("FAIL midreset_rdata got=%h exp=0000a014", d); else pass_cnt++;
    endtask

    initial begin
        pass_cnt                = 0;
        total_cnt               = 0;
        rst_n                   = 1'b0;
        bus.cpu_addr            = 16'h0;
        bus.cpu_req             = 1'b0;
        bus.flush               = 1'b0;
        bus.mem_data_read       = 32'h0;
        bus.mem_data_read_valid = 1'b0;
        bus.mem_finished        = 1'b0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_idle();
        test_flush_refill();
        test_extra_beat();
        test_reset_midfill();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
